vrf_read_port_scheduler: RTL and testbench

Shares one vector-register-file read port among NUM_PORTS read requesters (lane read stages, LSU, mask unit). Each cycle it grants at most one request round-robin, issues it to the VRF port, tracks it through the fixed-latency read pipeline, and steers the returned data into a per-requester response FIFO. Per-requester credits guarantee a granted read always has a FIFO slot, so the VRF return path is never backpressured. It sits between the read-stage arbiters and the VRF bank.

---
 rtl/vrf_read_port_scheduler.sv | 166 ++++++++++++++++
 tb/tb_vrf_read_port_scheduler.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vrf_read_port_scheduler.sv
// vrf_read_port_scheduler: round-robin sharing of one VRF read port with credit-backed per-requester response FIFOs
module vrf_read_port_scheduler #(
    parameter int NUM_PORTS    = 4,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 2,
    parameter int CREDITS      = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        io_req_valid,
    output logic [NUM_PORTS-1:0]        io_req_ready,
    input  logic [NUM_PORTS*5-1:0]      io_req_vs,
    input  logic [NUM_PORTS*4-1:0]      io_req_offset,
    input  logic [NUM_PORTS*3-1:0]      io_req_instructionIndex,
    output logic                        io_vrf_read_valid,
    input  logic                        io_vrf_read_ready,
    output logic [4:0]                  io_vrf_read_vs,
    output logic [3:0]                  io_vrf_read_offset,
    output logic [2:0]                  io_vrf_read_instructionIndex,
    input  logic [DATA_W-1:0]           io_vrf_read_data,
    output logic [NUM_PORTS-1:0]        io_resp_valid,
    input  logic [NUM_PORTS-1:0]        io_resp_ready,
    output logic [NUM_PORTS*DATA_W-1:0] io_resp_data
);
    localparam int IDW = $clog2(NUM_PORTS);
    localparam int CW  = $clog2(CREDITS + 1);
    localparam int PW  = CREDITS > 1 ? $clog2(CREDITS) : 1;
    localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDITS);
    localparam logic [PW-1:0] PTR_LAST   = PW'(CREDITS - 1);

    logic [IDW-1:0]       last_grant;
    logic [IDW-1:0]       winner;
    logic [IDW-1:0]       cand;
    logic [CW-1:0]        credit [NUM_PORTS];
    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] grant;
    logic [NUM_PORTS-1:0] push;
    logic [NUM_PORTS-1:0] pop;
    logic                 fire;
    logic                 trk_valid [READ_LATENCY];
    logic [IDW-1:0]       trk_id [READ_LATENCY];
    logic [DATA_W-1:0]    mem [NUM_PORTS][CREDITS];
    logic [PW-1:0]        rd_ptr [NUM_PORTS];
    logic [PW-1:0]        wr_ptr [NUM_PORTS];
    logic [CW-1:0]        count [NUM_PORTS];

    // A requester competes only with a free response slot; nothing competes while reset is held
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++)
            eligible[i] = reset & io_req_valid[i] & (credit[i] != '0);
    end

    // Round-robin search from last_grant+1; scanning downward lets the nearest candidate win
    always_comb begin
        winner = '0;
        cand   = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            cand = IDW'((int'(last_grant) + k) % NUM_PORTS);
            if (eligible[cand])
                winner = cand;
        end
        grant = '0;
        if (|eligible)
            grant[winner] = 1'b1;
    end

    assign io_vrf_read_valid = |eligible;
    assign fire              = io_vrf_read_valid & io_vrf_read_ready;
    assign io_req_ready      = grant & {NUM_PORTS{io_vrf_read_ready}};

    // Steer the winner's address and tag onto the VRF port, zero when idle
    always_comb begin
        io_vrf_read_vs               = '0;
        io_vrf_read_offset           = '0;
        io_vrf_read_instructionIndex = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) begin
                io_vrf_read_vs               = io_req_vs[i*5 +: 5];
                io_vrf_read_offset           = io_req_offset[i*4 +: 4];
                io_vrf_read_instructionIndex = io_req_instructionIndex[i*3 +: 3];
            end
        end
    end

    // Returned data lands in the FIFO of whichever requester reaches the end of the tracker
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            push[i]          = trk_valid[READ_LATENCY-1] & (trk_id[READ_LATENCY-1] == IDW'(i));
            io_resp_valid[i] = count[i] != '0;
            pop[i]           = io_resp_valid[i] & io_resp_ready[i];
            io_resp_data[i*DATA_W +: DATA_W] = io_resp_valid[i] ? mem[i][rd_ptr[i]] : '0;
        end
    end

    // Pointer only moves on an actual fire so a stalled winner keeps its priority
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            last_grant <= IDW'(NUM_PORTS - 1);
        else if (fire)
            last_grant <= winner;
    end

    // Fixed-latency tracker of in-flight reads; reset drops anything still in the VRF pipe
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < READ_LATENCY; s++) begin
                trk_valid[s] <= 1'b0;
                trk_id[s]    <= '0;
            end
        end else begin
            trk_valid[0] <= fire;
            trk_id[0]    <= winner;
            for (int s = 1; s < READ_LATENCY; s++) begin
                trk_valid[s] <= trk_valid[s-1];
                trk_id[s]    <= trk_id[s-1];
            end
        end
    end

    // Credits count free response slots: spent on accept, returned on pop
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PORTS; i++)
                credit[i] <= CREDIT_MAX;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++)
                credit[i] <= credit[i] - CW'(io_req_ready[i]) + CW'(pop[i]);
        end
    end

    // FIFO pointers and occupancy per requester
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (push[i])
                    wr_ptr[i] <= wr_ptr[i] == PTR_LAST ? '0 : wr_ptr[i] + 1'b1;
                if (pop[i])
                    rd_ptr[i] <= rd_ptr[i] == PTR_LAST ? '0 : rd_ptr[i] + 1'b1;
                count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
            end
        end
    end

    // FIFO storage needs no reset since occupancy gates the visible head
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_PORTS; i++)
            if (push[i])
                mem[i][wr_ptr[i]] <= io_vrf_read_data;
    end

    // Credit bookkeeping must keep the return path free of overflow
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                assert (credit[i] <= CREDIT_MAX);
                assert (!(push[i] && !pop[i] && count[i] == CREDIT_MAX));
            end
        end
    end
endmodule

// File: tb/tb_vrf_read_port_scheduler.sv
// tb_vrf_read_port_scheduler: scoreboard bench acting as requesters and as the VRF read pipe
module tb_vrf_read_port_scheduler;
    localparam int NP = 4;
    localparam int DW = 32;
    localparam int L  = 2;
    localparam int CR = 2;

    logic            clock;
    logic            reset;
    logic [NP-1:0]   io_req_valid;
    logic [NP-1:0]   io_req_ready;
    logic [NP*5-1:0] io_req_vs;
    logic [NP*4-1:0] io_req_offset;
    logic [NP*3-1:0] io_req_instructionIndex;
    logic            io_vrf_read_valid;
    logic            io_vrf_read_ready;
    logic [4:0]      io_vrf_read_vs;
    logic [3:0]      io_vrf_read_offset;
    logic [2:0]      io_vrf_read_instructionIndex;
    logic [DW-1:0]   io_vrf_read_data;
    logic [NP-1:0]   io_resp_valid;
    logic [NP-1:0]   io_resp_ready;
    logic [NP*DW-1:0] io_resp_data;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] exp_q [NP][$];
    logic          pipe_v [L];
    logic [DW-1:0] pipe_d [L];
    logic          fixed_en;
    logic [DW-1:0] fixed_d;

    logic [NP-1:0]    obs_ready;
    logic             obs_vrf_valid;
    logic [4:0]       obs_vs;
    logic [3:0]       obs_off;
    logic [2:0]       obs_tag;
    logic [NP-1:0]    obs_resp_valid;
    logic [NP*DW-1:0] obs_resp_data;
    int               obs_grant;
    int               fires;

    vrf_read_port_scheduler #(.NUM_PORTS(NP), .DATA_W(DW), .READ_LATENCY(L), .CREDITS(CR)) dut (
        .clock(clock),
        .reset(reset),
        .io_req_valid(io_req_valid),
        .io_req_ready(io_req_ready),
        .io_req_vs(io_req_vs),
        .io_req_offset(io_req_offset),
        .io_req_instructionIndex(io_req_instructionIndex),
        .io_vrf_read_valid(io_vrf_read_valid),
        .io_vrf_read_ready(io_vrf_read_ready),
        .io_vrf_read_vs(io_vrf_read_vs),
        .io_vrf_read_offset(io_vrf_read_offset),
        .io_vrf_read_instructionIndex(io_vrf_read_instructionIndex),
        .io_vrf_read_data(io_vrf_read_data),
        .io_resp_valid(io_resp_valid),
        .io_resp_ready(io_resp_ready),
        .io_resp_data(io_resp_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One cycle: present VRF data, observe settled outputs, score pops, record fires, advance
    task automatic tick();
        logic          nv;
        logic [DW-1:0] nd;
        io_vrf_read_data = pipe_v[L-1] ? pipe_d[L-1] : DW'($urandom());
        #1;
        obs_ready      = io_req_ready;
        obs_vrf_valid  = io_vrf_read_valid;
        obs_vs         = io_vrf_read_vs;
        obs_off        = io_vrf_read_offset;
        obs_tag        = io_vrf_read_instructionIndex;
        obs_resp_valid = io_resp_valid;
        obs_resp_data  = io_resp_data;
        obs_grant      = -1;
        for (int i = 0; i < NP; i++)
            if (io_req_ready[i]) obs_grant = i;
        for (int i = 0; i < NP; i++) begin
            if (io_resp_valid[i] && exp_q[i].size() == 0)
                check($sformatf("resp_unexp%0d", i), 128'(io_resp_valid[i]), 128'(0));
            else if (io_resp_valid[i] && io_resp_ready[i])
                check($sformatf("resp_data%0d", i), 128'(io_resp_data[i*DW +: DW]), 128'(exp_q[i].pop_front()));
        end
        nv = 1'b0;
        nd = '0;
        if (io_vrf_read_valid && io_vrf_read_ready) begin
            nv = 1'b1;
            nd = fixed_en ? fixed_d : DW'($urandom());
            if (obs_grant >= 0) exp_q[obs_grant].push_back(nd);
            else check("fire_no_grant", 128'(io_req_ready), 128'(1));
        end
        for (int s = L - 1; s > 0; s--) begin
            pipe_v[s] = pipe_v[s-1];
            pipe_d[s] = pipe_d[s-1];
        end
        pipe_v[0] = nv;
        pipe_d[0] = nd;
        @(negedge clock);
    endtask

    task automatic drain();
        io_req_valid  = '0;
        io_resp_ready = '1;
        for (int k = 0; k < 8; k++) tick();
        io_resp_ready = '0;
    endtask

    task automatic count_fires(input int r, input int n, output int c);
        c = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (obs_grant == r) c++;
        end
    endtask

    initial begin
        reset             = 1'b0;
        io_req_valid      = '1;
        io_vrf_read_ready = 1'b1;
        io_resp_ready     = '0;
        io_vrf_read_data  = '0;
        fixed_en          = 1'b0;
        fixed_d           = '0;
        for (int i = 0; i < NP; i++) begin
            io_req_vs[i*5 +: 5]               = 5'(8 + i);
            io_req_offset[i*4 +: 4]           = 4'(i);
            io_req_instructionIndex[i*3 +: 3] = 3'(i + 1);
        end
        for (int s = 0; s < L; s++) begin
            pipe_v[s] = 1'b0;
            pipe_d[s] = '0;
        end
        @(negedge clock);
        tick();
        check("rst_req_ready", 128'(obs_ready), 128'(0));
        check("rst_vrf_valid", 128'(obs_vrf_valid), 128'(0));
        check("rst_vrf_fields", 128'({obs_vs, obs_off, obs_tag}), 128'(0));
        check("rst_resp_valid", 128'(obs_resp_valid), 128'(0));
        check("rst_resp_data", 128'(obs_resp_data), 128'(0));

        reset         = 1'b1;
        io_resp_ready = '1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("rr_grant%0d", k), 128'(obs_grant), 128'(k % NP));
        end
        drain();

        io_req_vs[2*5 +: 5]               = 5'd5;
        io_req_offset[2*4 +: 4]           = 4'd3;
        io_req_instructionIndex[2*3 +: 3] = 3'd6;
        io_req_valid = 4'b0100;
        fixed_en     = 1'b1;
        fixed_d      = 32'hDEADBEEF;
        tick();
        check("lat_grant", 128'(obs_grant), 128'(2));
        check("lat_fields", 128'({obs_vs, obs_off, obs_tag}), 128'({5'd5, 4'd3, 3'd6}));
        io_req_valid = '0;
        fixed_en     = 1'b0;
        tick();
        check("lat_t1", 128'(obs_resp_valid), 128'(0));
        tick();
        check("lat_t2", 128'(obs_resp_valid), 128'(0));
        tick();
        check("lat_t3_valid", 128'(obs_resp_valid), 128'(4'b0100));
        check("lat_t3_data", 128'(obs_resp_data[2*DW +: DW]), 128'(32'hDEADBEEF));
        drain();

        io_req_valid = 4'b0010;
        tick();
        check("cr_fire1", 128'(obs_grant), 128'(1));
        tick();
        check("cr_fire2", 128'(obs_grant), 128'(1));
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("cr_block%0d", k), 128'(obs_ready), 128'(0));
        end
        check("cr_fifo_full", 128'(obs_resp_valid), 128'(4'b0010));
        io_resp_ready = 4'b0010;
        tick();
        check("cr_pop_cycle", 128'(obs_ready), 128'(0));
        io_resp_ready = '0;
        tick();
        check("cr_refire", 128'(obs_grant), 128'(1));
        tick();
        check("cr_block_again", 128'(obs_ready), 128'(0));
        drain();

        io_req_valid = 4'b0001;
        tick();
        check("st_pre", 128'(obs_grant), 128'(0));
        io_req_valid      = 4'b1010;
        io_vrf_read_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("st_ready%0d", k), 128'(obs_ready), 128'(0));
            check($sformatf("st_winner%0d", k), 128'({obs_vrf_valid, obs_vs}), 128'({1'b1, 5'd9}));
        end
        io_vrf_read_ready = 1'b1;
        tick();
        check("st_rel1", 128'(obs_grant), 128'(1));
        tick();
        check("st_rel2", 128'(obs_grant), 128'(3));
        drain();

        io_req_valid = 4'b0001;
        tick();
        tick();
        io_req_valid = '0;
        for (int k = 0; k < 3; k++) tick();
        io_resp_ready = 4'b0001;
        tick();
        check("ord_pop_only", 128'(obs_ready), 128'(0));
        io_req_valid = 4'b0001;
        tick();
        check("ord_pop_grant", 128'({obs_resp_valid[0], obs_ready}), 128'({1'b1, 4'b0001}));
        tick();
        check("ord_credit_kept", 128'(obs_grant), 128'(0));
        io_resp_ready = '0;
        tick();
        check("ord_credit_out", 128'(obs_ready), 128'(0));
        drain();

        io_req_valid = 4'b0100;
        tick();
        check("rm_fire", 128'(obs_grant), 128'(2));
        io_req_valid = '0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < NP; i++) exp_q[i].delete();
        for (int k = 0; k < 4; k++) tick();
        check("rm_no_resp", 128'(obs_resp_valid), 128'(0));
        io_req_valid = 4'b0100;
        count_fires(2, 6, fires);
        check("rm_credits", 128'(fires), 128'(CR));
        drain();

        check("sb_empty", 128'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
